cmd_serial: RTL and testbench
=============================

Name: cmd_serial

Overview:
- SD-card CMD-line serializer/deserializer. It shifts a 48-bit command packet out on cmd_out MSB-first, then captures the card's response from cmd_in.
- Response length is 48 bits (R1/R3/R6/R7) or 136 bits (R2).
- Sits below the command send/receive wrapper; that wrapper performs CRC7 checking and command-index checking on the packets this block delivers.

Parameters:
- TIMEOUT_CLKS, 64: maximum sd_clk cycles spent waiting for a response start bit (NCR limit) before giving up.

Ports:
- sd_clk  input  1  SD clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- r2_resp_enb  input  1  sampled with snd_cmd_strb; 1 means a 136-bit R2 response is expected.
- snd_cmd_strb  input  1  one-cycle request to send cmd_packet.
- cmd_packet  input  48  command frame, bit 47 (start bit) sent first.
- cmd_in  input  1  CMD line from card (idle high).
- cmd_out  output  1  CMD line to card; idles high.
- end_bit_det_strb  output  1  one-cycle pulse while the command end bit (cmd_packet[0]) is driven.
- new_resp_packet_strb  output  1  one-cycle pulse: new 48-bit response valid.
- new_r2_packet_strb  output  1  one-cycle pulse: new 136-bit response valid.
- resp_packet  output  48  last 48-bit response, bit 47 = start bit.
- resp2_packet  output  136  last R2 response, bit 135 = start bit.
- resp_timeout_strb  output  1  one-cycle pulse: no start bit seen within TIMEOUT_CLKS.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE; cmd_out=1.
  - All strobes 0; resp_packet=0, resp2_packet=0; counters 0.
  - A reset asserted mid-send or mid-receive aborts immediately; no strobe is produced.
- FSM states: IDLE, SEND, WAIT_START, RECV, DONE.
- IDLE:
  - On snd_cmd_strb=1, latch cmd_packet into a shift register, latch r2_resp_enb into r2_mode, go to SEND.
  - snd_cmd_strb in any state other than IDLE is ignored.
- SEND:
  - Cycle after the strobe edge: cmd_out=cmd_packet[47]. Each following cycle shifts left one bit.
  - Exactly 48 bits; bit 0 is driven in the 48th SEND cycle.
  - end_bit_det_strb=1 in that same cycle.
  - Next state WAIT_START; cmd_out returns to 1.
- WAIT_START:
  - Sample cmd_in each rising edge. The first 0 sampled is the start bit; it is stored as the MSB and the state moves to RECV.
  - Wait counter increments each cycle. On reaching TIMEOUT_CLKS without a start bit: pulse resp_timeout_strb for 1 cycle and go to IDLE. Commands with no response (e.g. CMD0) end this way.
- RECV:
  - Shift cmd_in into the capture register on each rising edge.
  - Total bits captured including the start bit: 48 if r2_mode=0, 136 if r2_mode=1.
  - After the last bit, go to DONE.
- DONE (1 cycle):
  - r2_mode=0: copy the capture register to resp_packet and assert new_resp_packet_strb. resp2_packet is unchanged.
  - r2_mode=1: copy to resp2_packet and assert new_r2_packet_strb. resp_packet is unchanged.
  - Return to IDLE. The output packet registers hold their value until the next completed response.
  - Latency: the strobe is 1 cycle after the edge that sampled the final response bit.
- No CRC, end-bit or index checking here. A response end bit of 0 is still delivered as-is.
- Bit counter:
  - Width 8 bits; covers 0..135 and TIMEOUT_CLKS up to 255.
  - Wrap-around never occurs because it is cleared on every state entry.

Decomposition:
- Shared package sd_cmd_pkg: state enum, CMD_LEN=48, R1_LEN=48, R2_LEN=136, default NCR timeout 64.
- One natural sub-module: counter_seq, a start-strobed up-counter to a max value with a terminal strobe. Reuse it for the send, receive and timeout counts.
- CRC7 stays outside this block.

Test Plan:
- Reset: hold reset=0 during active traffic, release -> cmd_out=1, all strobes 0, resp_packet=0, state IDLE; no strobe after release.
- CMD8 send: cmd_packet=48'h48_000001AA_87, strobe -> cmd_out serially equals the packet MSB-first over 48 cycles; end_bit_det_strb high only with bit 0=1.
- R1 receive: after send, drive 3 idle-high cycles then 48'h08_000001AA_13 on cmd_in -> one new_resp_packet_strb pulse; resp_packet=48'h08000001AA13; new_r2_packet_strb=0.
- R2 receive: r2_resp_enb=1 with CMD2, drive a 136-bit frame starting 8'h3F... -> new_r2_packet_strb pulse; resp2_packet equals the frame; resp_packet unchanged.
- Timeout: CMD0 48'h40_00000000_95, cmd_in held 1 -> resp_timeout_strb pulse exactly 64 cycles after the end bit; no packet strobes; back to IDLE.
- Busy ignore: second snd_cmd_strb during SEND -> ignored; only the first packet appears on cmd_out.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared types and frame lengths for the SD CMD-line serializer.
// All sequencing counts use one 8-bit width; the longest count is 135.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND       = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_RECV       = 3'd3,
        ST_DONE       = 3'd4
    } cmd_state_e;

    localparam int CMD_LEN         = 48;
    localparam int R1_LEN          = 48;
    localparam int R2_LEN          = 136;
    localparam int NCR_TIMEOUT_DEF = 64;
    localparam int CNT_W           = 8;

    // Terminal count value for a phase lasting n cycles (counter runs 0..n-1).
    function automatic logic [CNT_W-1:0] cnt_max(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/cmd_serial_counter_seq.sv
// Start-strobed up-counter: cleared by start, counts while enabled, and
// flags the cycle in which it sits at max_val.
module counter_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         en,
    input  logic [W-1:0] max_val,
    output logic         term
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (en && (cnt_q != max_val)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = en && (cnt_q == max_val);

endmodule

// File: rtl/cmd_serial.sv
// SD CMD-line serializer/deserializer: shifts a 48-bit command out MSB-first,
// then captures an R1-style (48) or R2 (136) response from cmd_in.
//
// state       | meaning
// ST_IDLE     | cmd_out high, waiting for snd_cmd_strb
// ST_SEND     | driving the 48 command bits, MSB first
// ST_WAIT_START | watching cmd_in for the response start bit (NCR window)
// ST_RECV     | shifting in the remaining response bits
// ST_DONE     | one cycle; response strobe and packet register valid
module cmd_serial
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = NCR_TIMEOUT_DEF
) (
    input  logic                sd_clk,
    input  logic                reset,
    input  logic                r2_resp_enb,
    input  logic                snd_cmd_strb,
    input  logic [CMD_LEN-1:0]  cmd_packet,
    input  logic                cmd_in,
    output logic                cmd_out,
    output logic                end_bit_det_strb,
    output logic                new_resp_packet_strb,
    output logic                new_r2_packet_strb,
    output logic [R1_LEN-1:0]   resp_packet,
    output logic [R2_LEN-1:0]   resp2_packet,
    output logic                resp_timeout_strb
);

    localparam logic [CNT_W-1:0] SEND_MAX = cnt_max(CMD_LEN);
    // The timeout strobe is registered, so the window closes one cycle early
    // and the pulse itself lands TIMEOUT_CLKS cycles after the end bit.
    localparam logic [CNT_W-1:0] WAIT_MAX = cnt_max(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] R1_MAX   = cnt_max(R1_LEN - 1);
    localparam logic [CNT_W-1:0] R2_MAX   = cnt_max(R2_LEN - 1);

    cmd_state_e          state_q, state_d;
    logic [CMD_LEN-1:0]  shift_q, shift_d;
    logic                r2_mode_q, r2_mode_d;
    logic [R2_LEN-1:0]   cap_q, cap_d;
    logic [R1_LEN-1:0]   resp_q, resp_d;
    logic [R2_LEN-1:0]   resp2_q, resp2_d;
    logic                new_resp_q, new_resp_d;
    logic                new_r2_q, new_r2_d;
    logic                timeout_q, timeout_d;

    logic                in_send, in_wait, in_recv;
    logic                send_start, wait_start, recv_start;
    logic                send_term, wait_term, recv_term;
    logic [CNT_W-1:0]    recv_max;

    assign in_send  = (state_q == ST_SEND);
    assign in_wait  = (state_q == ST_WAIT_START);
    assign in_recv  = (state_q == ST_RECV);
    assign recv_max = r2_mode_q ? R2_MAX : R1_MAX;

    assign send_start = (state_d == ST_SEND)       && !in_send;
    assign wait_start = (state_d == ST_WAIT_START) && !in_wait;
    assign recv_start = (state_d == ST_RECV)       && !in_recv;

    counter_seq #(.W(CNT_W)) u_send_cnt (
        .clk     (sd_clk),
        .rst_n   (reset),
        .start   (send_start),
        .en      (in_send),
        .max_val (SEND_MAX),
        .term    (send_term)
    );

    counter_seq #(.W(CNT_W)) u_wait_cnt (
        .clk     (sd_clk),
        .rst_n   (reset),
        .start   (wait_start),
        .en      (in_wait),
        .max_val (WAIT_MAX),
        .term    (wait_term)
    );

    counter_seq #(.W(CNT_W)) u_recv_cnt (
        .clk     (sd_clk),
        .rst_n   (reset),
        .start   (recv_start),
        .en      (in_recv),
        .max_val (recv_max),
        .term    (recv_term)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        r2_mode_d  = r2_mode_q;
        cap_d      = cap_q;
        resp_d     = resp_q;
        resp2_d    = resp2_q;
        new_resp_d = 1'b0;
        new_r2_d   = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (snd_cmd_strb) begin
                    shift_d   = cmd_packet;
                    r2_mode_d = r2_resp_enb;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                shift_d = {shift_q[CMD_LEN-2:0], 1'b1};
                if (send_term) begin
                    state_d = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (!cmd_in) begin
                    // The start bit is a zero, so a cleared register already holds it.
                    cap_d   = '0;
                    state_d = ST_RECV;
                end else if (wait_term) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RECV: begin
                cap_d = {cap_q[R2_LEN-2:0], cmd_in};
                if (recv_term) begin
                    state_d = ST_DONE;
                    if (r2_mode_q) begin
                        resp2_d  = cap_d;
                        new_r2_d = 1'b1;
                    end else begin
                        resp_d     = cap_d[R1_LEN-1:0];
                        new_resp_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sd_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            r2_mode_q  <= 1'b0;
            cap_q      <= '0;
            resp_q     <= '0;
            resp2_q    <= '0;
            new_resp_q <= 1'b0;
            new_r2_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            r2_mode_q  <= r2_mode_d;
            cap_q      <= cap_d;
            resp_q     <= resp_d;
            resp2_q    <= resp2_d;
            new_resp_q <= new_resp_d;
            new_r2_q   <= new_r2_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cmd_out              = in_send ? shift_q[CMD_LEN-1] : 1'b1;
    assign end_bit_det_strb     = in_send && send_term;
    assign new_resp_packet_strb = new_resp_q;
    assign new_r2_packet_strb   = new_r2_q;
    assign resp_timeout_strb    = timeout_q;
    assign resp_packet          = resp_q;
    assign resp2_packet         = resp2_q;

endmodule

// File: tb/tb_cmd_serial.sv
// Randomized bench for cmd_serial: commands and card responses are scheduled
// cycle by cycle and compared against expectations derived from frame timing.
module tb_cmd_serial;

    localparam int TIMEOUT_CLKS = 64;

    logic         sd_clk;
    logic         reset;
    logic         r2_resp_enb;
    logic         snd_cmd_strb;
    logic [47:0]  cmd_packet;
    logic         cmd_in;
    logic         cmd_out;
    logic         end_bit_det_strb;
    logic         new_resp_packet_strb;
    logic         new_r2_packet_strb;
    logic [47:0]  resp_packet;
    logic [135:0] resp2_packet;
    logic         resp_timeout_strb;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0]  exp_r1 = '0;
    logic [135:0] exp_r2 = '0;

    cmd_serial #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
        .sd_clk               (sd_clk),
        .reset                (reset),
        .r2_resp_enb          (r2_resp_enb),
        .snd_cmd_strb         (snd_cmd_strb),
        .cmd_packet           (cmd_packet),
        .cmd_in               (cmd_in),
        .cmd_out              (cmd_out),
        .end_bit_det_strb     (end_bit_det_strb),
        .new_resp_packet_strb (new_resp_packet_strb),
        .new_r2_packet_strb   (new_r2_packet_strb),
        .resp_packet          (resp_packet),
        .resp2_packet         (resp2_packet),
        .resp_timeout_strb    (resp_timeout_strb)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_lines"}, 136'({cmd_out, end_bit_det_strb, new_resp_packet_strb,
                                     new_r2_packet_strb, resp_timeout_strb}), 136'(5'b10000));
    endtask

    function automatic logic [135:0] rand_frame(input int len);
        logic [159:0] raw;
        logic [135:0] f;
        for (int w = 0; w < 5; w++) raw[w*32 +: 32] = $urandom;
        f = raw[135:0];
        if (len == 48) f = {88'b0, f[47:0]};
        f[len-1] = 1'b0;
        return f;
    endfunction

    // One full command: send, optional response after d idle cycles, then expected strobe.
    task automatic run_cmd(input logic [47:0] pkt, input bit r2, input int d,
                           input bit respond, input logic [135:0] frame, input bit busy);
        int len;
        int exp_cyc;
        bit hit;
        len     = r2 ? 136 : 48;
        hit     = respond && (d + 1 < TIMEOUT_CLKS);
        exp_cyc = hit ? d + len + 1 : TIMEOUT_CLKS;

        @(negedge sd_clk);
        cmd_packet   = pkt;
        r2_resp_enb  = r2;
        snd_cmd_strb = 1'b1;
        cmd_in       = 1'b1;
        @(negedge sd_clk);
        snd_cmd_strb = 1'b0;
        cmd_packet   = 48'({$urandom, $urandom});
        r2_resp_enb  = 1'($urandom);

        for (int i = 0; i < 48; i++) begin
            check("cmd_out_bit", 136'(cmd_out), 136'(pkt[47-i]));
            check("end_bit_strb", 136'(end_bit_det_strb), 136'(i == 47));
            if (busy && i == 10) begin
                snd_cmd_strb = 1'b1;
                cmd_packet   = ~pkt;
                r2_resp_enb  = ~r2;
            end else begin
                snd_cmd_strb = 1'b0;
            end
            @(negedge sd_clk);
        end

        for (int k = 1; k <= exp_cyc + 1; k++) begin
            logic [2:0] exp_s;
            exp_s = 3'b000;
            if (k == exp_cyc) begin
                if (hit) begin
                    exp_s = r2 ? 3'b001 : 3'b010;
                    if (r2) exp_r2 = frame;
                    else    exp_r1 = frame[47:0];
                end else begin
                    exp_s = 3'b100;
                end
            end
            if (k == 1) check("cmd_out_idle_after_send", 136'(cmd_out), 136'(1'b1));
            check("strobes_tmo_r1_r2",
                  136'({resp_timeout_strb, new_resp_packet_strb, new_r2_packet_strb}), 136'(exp_s));
            if (k == exp_cyc) begin
                check("resp_packet", 136'(resp_packet), 136'(exp_r1));
                check("resp2_packet", resp2_packet, exp_r2);
            end
            cmd_in = (respond && k > d && (k - d - 1) < len) ? frame[len-1-(k-d-1)] : 1'b1;
            @(negedge sd_clk);
        end
        cmd_in = 1'b1;
    endtask

    // Start a command, assert reset after n cycles, and confirm nothing leaks out afterwards.
    task automatic abort_with_reset(input int n, input bit in_recv);
        @(negedge sd_clk);
        cmd_packet   = 48'({$urandom, $urandom});
        r2_resp_enb  = 1'b0;
        snd_cmd_strb = 1'b1;
        cmd_in       = 1'b1;
        @(negedge sd_clk);
        snd_cmd_strb = 1'b0;
        for (int c = 0; c < n; c++) begin
            cmd_in = (in_recv && c >= 48) ? 1'($urandom) & (c != 48 ? 1'b1 : 1'b0) : 1'b1;
            @(negedge sd_clk);
        end
        #2 reset = 1'b0;
        #1;
        exp_r1 = '0;
        exp_r2 = '0;
        check_quiet("abort_in_reset");
        check("abort_resp_packet", 136'(resp_packet), 136'(exp_r1));
        check("abort_resp2_packet", resp2_packet, exp_r2);
        @(negedge sd_clk);
        reset  = 1'b1;
        cmd_in = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge sd_clk);
            check_quiet("abort_after_release");
        end
    endtask

    initial begin
        logic [135:0] frame;
        reset        = 1'b0;
        r2_resp_enb  = 1'b0;
        snd_cmd_strb = 1'b0;
        cmd_packet   = '0;
        cmd_in       = 1'b1;

        // Traffic while held in reset must be ignored.
        for (int c = 0; c < 8; c++) begin
            @(negedge sd_clk);
            snd_cmd_strb = 1'($urandom);
            cmd_packet   = 48'({$urandom, $urandom});
            cmd_in       = 1'($urandom);
            check_quiet("in_reset");
        end
        check("reset_resp_packet", 136'(resp_packet), 136'(0));
        check("reset_resp2_packet", resp2_packet, 136'(0));
        @(negedge sd_clk);
        snd_cmd_strb = 1'b0;
        cmd_in       = 1'b1;
        reset        = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge sd_clk);
            check_quiet("after_release");
        end

        run_cmd(48'h48_000001AA_87, 1'b0, 3, 1'b1, {88'b0, 48'h08_000001AA_13}, 1'b0);

        frame = rand_frame(136);
        frame[135:128] = 8'h3F;
        run_cmd(48'h42_00000000_4D, 1'b1, 5, 1'b1, frame, 1'b0);

        abort_with_reset(70, 1'b1);

        run_cmd(48'h40_00000000_95, 1'b0, 0, 1'b0, '0, 1'b0);
        run_cmd(48'h51_00001234_AB, 1'b0, 2, 1'b1, rand_frame(48), 1'b1);

        // Last accepted start position, then the first one that is too late.
        run_cmd(48'h4D_12345678_3B, 1'b0, TIMEOUT_CLKS - 2, 1'b1, rand_frame(48), 1'b0);
        run_cmd(48'h4D_12345678_3B, 1'b0, TIMEOUT_CLKS - 1, 1'b1, rand_frame(48), 1'b0);
        run_cmd(48'h42_00000000_4D, 1'b1, 0, 1'b1, rand_frame(136), 1'b0);

        for (int t = 0; t < 12; t++) begin
            bit r2;
            r2 = 1'($urandom_range(0, 1));
            run_cmd(48'({$urandom, $urandom}), r2, $urandom_range(0, 70),
                    $urandom_range(0, 3) != 0, rand_frame(r2 ? 136 : 48), 1'($urandom_range(0, 1)));
        end

        abort_with_reset(20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
